block_data_memory: RTL
======================

# block_data_memory

Word-organised backing data memory: the responder on the cache-to-memory block interface. It serves 32-bit block reads and write-backs issued by the data cache controller. Each access takes a programmable number of cycles, and the block holds `mem_busywait` high for that whole time. It sits between the data cache and the rest of the system as the single memory endpoint for data traffic.

## Interface
- `DEPTH`, 64: number of 32-bit blocks; the address width is 6.
- `LATENCY`, 5: cycles from request capture to access completion. Legal range is 1 to 15.
- `clock` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: reset, asynchronous, active-high.
- `mem_read` input, 1 bit: block read request, level-held by the requester.
- `mem_write` input, 1 bit: block write request, level-held by the requester.
- `mem_address` input, 6 bits: block address, formed as {tag, index}.
- `mem_writedata` input, 32 bits: write data; byte 0 sits in bits [7:0].
- `mem_readdata` output, 32 bits: read data, registered.
- `mem_busywait` output, 1 bit: high while a request is pending or in progress.

## Operation
- Storage is an array of DEPTH × 32-bit words.
  - Reset does not clear the array.
  - Contents are undefined until written.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - `mem_busywait` = `mem_read` | `mem_write`, driven combinationally so the requester sees a stall in the same cycle it asserts a request.
  - On a rising edge with a request present, capture the address, the write data and the operation into internal registers.
  - Load `lat_cnt` with LATENCY-1 and go to BUSY.
- BUSY:
  - `mem_busywait` = 1.
  - At each edge, if `lat_cnt` ≠ 0, decrement it.
  - If `lat_cnt` = 0, perform the captured access and go to DONE:
    - write: array[addr] ← data.
    - read: `mem_readdata` ← array[addr].
- DONE:
  - `mem_busywait` = 0 for exactly one cycle.
  - At the next edge, always go to IDLE.
  - If the request is still asserted in IDLE, a new access begins. This supports back-to-back write-back followed by fetch.
- Request changes during BUSY have no effect, because operands are captured at entry.
- `mem_read` and `mem_write` asserted together is illegal. The write is performed and `mem_readdata` is unchanged.
- `mem_readdata` holds its last read value until the next read completes. It is not cleared by writes or by returning to IDLE.
- Addresses are exactly 6 bits, so there is no wrap-around logic. Address 63 is a valid block.

## Timing
- Reset values:
  - state = IDLE.
  - `lat_cnt` = 0.
  - `mem_readdata` = 32'h0.
  - `mem_busywait` = 0 while `reset` is high, regardless of the request inputs.
- Request first seen at edge N:
  - The access happens at edge N+LATENCY.
  - `mem_busywait` goes low during cycle N+LATENCY to N+LATENCY+1.
  - Read data is valid in that same DONE cycle.
- `mem_busywait` is high for LATENCY+1 cycles per access: the request cycle plus LATENCY cycles in BUSY.
- The requester must sample `mem_readdata` or move on at the edge that ends DONE.
- Reset asserted mid-BUSY:
  - The access is aborted immediately; a pending write is not committed.
  - Array contents from earlier accesses are retained.

## Structure
- A shared package holds:
  - the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - the address width 6 and data width 32;
  - the default LATENCY.
- One sub-module is natural: `mem_word_array`, a 64×32 synchronous-write, synchronous-read array with write enable. The FSM and latency counter stay in the top module.

## Test plan
- Reset with no requests: `mem_busywait` = 0, `mem_readdata` = 32'h0, state IDLE.
- Write 32'hDEADBEEF to 6'h05:
  - `mem_busywait` is high for 6 cycles with LATENCY=5.
  - Then read 6'h05: `mem_readdata` = 32'hDEADBEEF in the DONE cycle.
- Back-to-back write then read, with the request held across DONE:
  - Write 32'h01234567 to 6'h3F, then read 6'h12 (previously written as 32'hA5A5A5A5).
  - Both complete; `mem_readdata` = 32'hA5A5A5A5; `mem_busywait` drops for exactly one cycle between them.
- Mid-BUSY operand change:
  - Write 32'h11111111 to 6'h08, then switch the address to 6'h09 and the data to 32'h22222222 after 2 cycles.
  - Read-back shows 6'h08 = 32'h11111111 and 6'h09 unchanged.
- Reset mid-BUSY write:
  - Set 6'h20 = 32'hCAFEF00D, start writing 32'h0 to 6'h20, and pulse reset at cycle 3.
  - Result: `mem_readdata` = 0 immediately; a later read of 6'h20 returns 32'hCAFEF00D.
- Simultaneous read and write of 32'h55AA55AA to 6'h00:
  - The write is committed and `mem_readdata` is unchanged.
  - A later read of 6'h00 returns 32'h55AA55AA.
  - Repeat with LATENCY=1: `mem_busywait` is high for 2 cycles.

Source files
------------

// File: rtl/block_data_memory_pkg.sv
// Shared definitions for the cache-facing backing data memory:
// widths, default access latency and the access FSM encoding.
package block_data_memory_pkg;

    localparam int ADDR_WIDTH      = 6;
    localparam int DATA_WIDTH      = 32;
    localparam int DEFAULT_LATENCY = 5;
    localparam int CNT_WIDTH       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Word storage with synchronous write and a registered synchronous read port.
// Only the read register is reset; the storage keeps its contents through reset.
module mem_word_array
    import block_data_memory_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] words [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            words[address] <= write_data;
        end
    end

    // Read data holds its last value until another read is performed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data <= '0;
        end else if (read_enable) begin
            read_data <= words[address];
        end
    end

endmodule

// File: rtl/block_data_memory.sv
// Block read / write-back responder for the data cache. Requests are captured on
// entry, held for LATENCY cycles, then performed; busywait covers the whole access.
module block_data_memory
    import block_data_memory_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_writedata,
    output logic [DATA_WIDTH-1:0] mem_readdata,
    output logic                  mem_busywait
);

    localparam logic [CNT_WIDTH-1:0] LAT_LOAD = CNT_WIDTH'(LATENCY - 1);

    state_t                state;
    state_t                next_state;
    logic [CNT_WIDTH-1:0]  lat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  write_q;
    logic                  request;
    logic                  access_now;
    logic                  busy_raw;

    assign request    = mem_read | mem_write;
    assign access_now = (state == BUSY) && (lat_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operands are frozen at capture so requester changes mid-access are ignored.
    // A simultaneous read and write is captured as a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else if (state == IDLE && request) begin
            lat_cnt <= LAT_LOAD;
            addr_q  <= mem_address;
            data_q  <= mem_writedata;
            write_q <= mem_write;
        end else if (state == BUSY && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        next_state = state;
        busy_raw   = 1'b0;
        case (state)
            IDLE: begin
                busy_raw = request;
                if (request) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                busy_raw = 1'b1;
                if (lat_cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The requester must never see a stall while the memory is held in reset.
    assign mem_busywait = busy_raw & ~reset;

    mem_word_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clock        (clock),
        .reset        (reset),
        .write_enable (access_now & write_q),
        .read_enable  (access_now & ~write_q),
        .address      (addr_q),
        .write_data   (data_q),
        .read_data    (mem_readdata)
    );

endmodule
